// File: rtl/matrix_engine_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle matrix engine among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining MAT_ARB_TIMEOUT_EN.
module matrix_engine_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] sel_idx,
  output logic [NUM_REQ-1:0]         req_done,
  output logic                       err_timeout,
  output logic                       busy,
  output logic                       eng_start,
  input  logic                       eng_done
);

  localparam int IDX_W = $clog2(NUM_REQ);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_START   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]     NUM_EXT  = (IDX_W + 1)'(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("matrix_engine_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic [1:0]           state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     next_ptr;
  logic                 win_vld;
  logic                 timeout_hit;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IDX_W:0]       win_sum;

  // Rotate req so rr_ptr sits at bit 0; the lowest set bit of the rotated vector wins.
  always_comb begin
    req_dbl = {req, req} >> rr_ptr;
    req_rot = req_dbl[NUM_REQ-1:0];
    win_vld = |req;
    win_sum = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) win_sum = (IDX_W + 1)'(i);
    end
    win_sum = win_sum + {1'b0, rr_ptr};
    if (win_sum >= NUM_EXT) win_sum = win_sum - NUM_EXT;
    win_idx = win_sum[IDX_W-1:0];
  end

  assign next_ptr = (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      sel_idx   <= '0;
      req_done  <= '0;
      eng_start <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (win_vld) begin
            grant     <= ONE_HOT0 << win_idx;
            sel_idx   <= win_idx;
            eng_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_START;
          end
        end
        ST_START: begin
          eng_start <= 1'b0;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (eng_done || timeout_hit) begin
            req_done <= grant;
            grant    <= '0;
            rr_ptr   <= next_ptr;
            state    <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          req_done <= '0;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MAT_ARB_TIMEOUT_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wdog;

  // Fires on the WAIT cycle whose increment would bring the count to TIMEOUT_CYCLES.
  assign timeout_hit = (state == ST_WAIT) && !eng_done && (wdog == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog        <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == ST_START) begin
        wdog <= '0;
      end else if (state == ST_WAIT && !eng_done && !timeout_hit) begin
        wdog <= wdog + 1'b1;
      end
      err_timeout <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_engine_arbiter.sv
// Scoreboard bench for matrix_engine_arbiter: a transaction-level reference model predicts
// grant and completion events, a monitor pops and compares them as the DUT presents them.
module tb_matrix_engine_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic [IW-1:0] sel_idx;
  logic [N-1:0]  req_done;
  logic          err_timeout;
  logic          busy;
  logic          eng_start;
  logic          eng_done;

  always #5 clk = ~clk;

  matrix_engine_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .sel_idx(sel_idx),
    .req_done(req_done), .err_timeout(err_timeout), .busy(busy),
    .eng_start(eng_start), .eng_done(eng_done)
  );

  typedef struct {
    int idx;
    int cyc;
    bit err;
  } ev_t;

  ev_t gq[$];
  ev_t dq[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;

  int  eng_lat    = 16;
  bit  start_spur = 1'b0;
  int  spur_req   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a single shared resource, owner -1 when free; one START cycle,
  // completion on eng_done (or timeout), one dead cycle before the next arbitration.
  initial begin : ref_model
    int owner, cool, age, wd, rr;
    bit fin, err;
    ev_t e;
    owner = -1; cool = 0; age = 0; wd = 0; rr = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        owner = -1; rr = 0; cool = 0;
      end else if (owner < 0) begin
        if (cool > 0) cool--;
        else if (req != 0) begin
          for (int k = 0; k < N; k++) begin
            if (req[(rr + k) % N]) begin
              owner = (rr + k) % N;
              break;
            end
          end
          e.idx = owner; e.cyc = cyc; e.err = 1'b0;
          gq.push_back(e);
          age = 0;
        end
      end else if (age == 0) begin
        age = 1; wd = 0;
      end else begin
        fin = 1'b0; err = 1'b0;
        if (eng_done) fin = 1'b1;
`ifdef MAT_ARB_TIMEOUT_EN
        else begin
          wd = wd + 1;
          if (wd == TO) begin fin = 1'b1; err = 1'b1; end
        end
`endif
        if (fin) begin
          e.idx = owner; e.cyc = cyc; e.err = err;
          dq.push_back(e);
          rr = (owner + 1) % N;
          owner = -1;
          cool = 1;
        end
      end
    end
  end

  // Monitor: compares DUT events against the predicted queues, sampled mid-cycle.
  initial begin : monitor
    ev_t e;
    logic prev_start;
    int last_done;
    prev_start = 1'b0;
    last_done  = -10;
    forever begin
      @(negedge clk);
      if (eng_start === 1'b1) begin
        if (gq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_grant actual=%0h required=none (cycle %0d)", grant, cyc);
        end else begin
          e = gq.pop_front();
          chk("grant", grant, 32'(1) << e.idx);
          chk("sel_idx", sel_idx, e.idx);
          chk("grant_cycle", cyc, e.cyc);
          chk("busy_on_grant", busy, 1);
          chk("start_width", prev_start, 0);
        end
      end
      if (req_done !== '0) begin
        if (dq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done actual=%0h required=none (cycle %0d)", req_done, cyc);
        end else begin
          e = dq.pop_front();
          chk("req_done", req_done, 32'(1) << e.idx);
          chk("err_timeout", err_timeout, e.err);
          chk("done_cycle", cyc, e.cyc);
          chk("grant_cleared", grant, 0);
          last_done = cyc;
        end
      end
      if (cyc == last_done + 1) begin
        chk("busy_after_release", busy, 0);
        chk("done_width", req_done, 0);
      end
      prev_start = eng_start;
    end
  end

  // Engine model: done pulse eng_lat cycles after start (0 = never, -1 = random),
  // plus injected spurious pulses.
  initial begin : engine
    int cnt;
    int ack;
    cnt = 0; ack = 0;
    eng_done = 1'b0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) eng_done = 1'b1;
      end
      if (spur_req != ack) begin
        ack = spur_req;
        eng_done = 1'b1;
      end
      if (eng_start === 1'b1) begin
        if (start_spur) eng_done = 1'b1;
        if (eng_lat > 0) cnt = eng_lat;
        else if (eng_lat < 0) cnt = $urandom_range(1, 12);
        else cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_dones(input int n, input bit drop, input int max_cyc);
    int seen;
    seen = 0;
    for (int c = 0; c < max_cyc && seen < n; c++) begin
      tick();
      if (req_done != '0) begin
        seen++;
        if (drop) req = req & ~req_done;
      end
    end
    chk("done_count", seen, n);
  endtask

  task automatic drain(input int max_cyc);
    bit idle;
    idle = 1'b0;
    req = '0;
    for (int c = 0; c < max_cyc && !idle; c++) begin
      tick();
      idle = !busy;
    end
    chk("drain_idle", idle, 1);
  endtask

  task automatic check_all_zero();
    chk("rst_grant", grant, 0);
    chk("rst_sel_idx", sel_idx, 0);
    chk("rst_req_done", req_done, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_eng_start", eng_start, 0);
  endtask

  initial begin : stimulus
    int order[5];
    int n;
    rst = 1'b1;
    req = '0;
    repeat (2) tick();
    check_all_zero();
    rst = 1'b0;

    // Single requester, 16-cycle engine.
    req = 4'b0100;
    eng_lat = 16;
    run_dones(1, 1'b1, 100);
    drain(50);

    // rr_ptr now 3: requester 3 then wrap to 0.
    req = 4'b1001;
    eng_lat = 3;
    run_dones(2, 1'b1, 100);
    drain(50);

    // Spurious done while idle.
    spur_req++;
    repeat (3) tick();
    chk("spur_idle_busy", busy, 0);
    chk("spur_idle_done", req_done, 0);

    // Spurious done in START, then owner drops req mid-WAIT.
    start_spur = 1'b1;
    eng_lat = 6;
    req = 4'b0010;
    repeat (4) tick();
    req = '0;
    run_dones(1, 1'b0, 50);
    start_spur = 1'b0;
    drain(50);

    // Engine never completes, then reset in WAIT.
    eng_lat = 0;
    req = 4'b0001;
    repeat (1000) tick();
`ifndef MAT_ARB_TIMEOUT_EN
    chk("stuck_busy", busy, 1);
    chk("stuck_grant", grant, 4'b0001);
`endif
    rst = 1'b1;
    tick();
    check_all_zero();
    rst = 1'b0;
    eng_lat = 4;
    run_dones(1, 1'b1, 50);
    drain(50);

    // All requesters held: order 0,1,2,3,0 from a fresh pointer.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    eng_lat = -1;
    req = 4'b1111;
    n = 0;
    for (int c = 0; c < 200 && n < 5; c++) begin
      tick();
      if (eng_start) begin
        order[n] = int'(sel_idx);
        n++;
      end
    end
    run_dones(1, 1'b0, 50);
    drain(50);
    chk("rr_count", n, 5);
    for (int k = 0; k < 5; k++) chk("rr_order", order[k], k % N);

    // Randomised traffic with owner drops and stray done pulses.
    eng_lat = -1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      req = req & ~req_done;
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
        else if (grant[i] && !eng_start && $urandom_range(0, 15) == 0) req[i] = 1'b0;
      end
      if ($urandom_range(0, 63) == 0) spur_req++;
    end
    eng_lat = 3;
    drain(200);
    repeat (3) tick();
    chk("grant_queue_empty", gq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout actual=%0d required=finished", cyc);
    $fatal(1, "bench timeout");
  end

endmodule
